// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder for the sequence detector.
// A one-word hold buffer in front of the shifter keeps back-to-back words gap-free.
module serial_bit_source #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             enable,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             word_start,
   output logic             underrun,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             word_start_q, word_start_d;
   logic             underrun_q, underrun_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic             accept;

   assign data_ready = ~hold_full_q & ~rst;
   assign accept     = data_valid & data_ready;
   assign busy       = active_q | hold_full_q;
   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign word_start = word_start_q;
   assign underrun   = underrun_q;
   assign words_sent = words_q;

   always_comb begin
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      sh_d         = sh_q;
      cnt_d        = cnt_q;
      active_d     = active_q;
      bit_out_d    = bit_out_q;
      bit_valid_d  = 1'b0;
      word_start_d = 1'b0;
      underrun_d   = 1'b0;
      words_d      = words_q;

      if (enable) begin
         if (active_q) begin
            if (MSB_FIRST) begin
               bit_out_d = sh_q[WIDTH-1];
               sh_d      = sh_q << 1;
            end else begin
               bit_out_d = sh_q[0];
               sh_d      = sh_q >> 1;
            end
            bit_valid_d = 1'b1;
            cnt_d       = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               active_d = 1'b0;
            end
         end else if (hold_full_q) begin
            // First bit goes straight from the hold buffer, no bubble.
            if (MSB_FIRST) begin
               bit_out_d = hold_q[WIDTH-1];
               sh_d      = hold_q << 1;
            end else begin
               bit_out_d = hold_q[0];
               sh_d      = hold_q >> 1;
            end
            cnt_d        = CW'(1);
            active_d     = 1'b1;
            hold_full_d  = 1'b0;
            bit_valid_d  = 1'b1;
            word_start_d = 1'b1;
            words_d      = words_q + CNT_W'(1);
         end else begin
            bit_out_d  = IDLE_BIT;
            underrun_d = bit_valid_q;
         end
      end

      // Never collides with the drain: ready is low while hold is full.
      if (accept) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         sh_q         <= '0;
         cnt_q        <= '0;
         active_q     <= 1'b0;
         bit_out_q    <= IDLE_BIT;
         bit_valid_q  <= 1'b0;
         word_start_q <= 1'b0;
         underrun_q   <= 1'b0;
         words_q      <= '0;
      end else begin
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         sh_q         <= sh_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         word_start_q <= word_start_d;
         underrun_q   <= underrun_d;
         words_q      <= words_d;
      end
   end

endmodule
